forward_stall_unit: RTL and testbench

//  Parametrised operand-forwarding and load-use stall controller for the EX stage.
//  - Keeps its own shadow pipeline of pending register writes: NUM_STAGES slots after EX.
//  - Per EX source operand: selects the nearest forwarding source, or requests a stall

---
 rtl/forward_stall_unit.sv | 102 ++++++++++
 tb/tb_forward_stall_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_stall_unit.sv
// Operand-forwarding select and load-use stall controller for the EX stage, backed by a shadow pipeline of pending writes.
// Optional stall statistics counter (o_StallCount) is built when FWD_STALL_STATS_EN is defined.
module forward_stall_unit #(
    parameter  int REG_WIDTH  = 5,
    parameter  int NUM_SRC    = 2,
    parameter  int NUM_STAGES = 3,
    parameter  int AVAIL_W    = 2,
    localparam int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                         i_Clock,
    input  logic                         i_Reset,
    input  logic                         i_Hold,
    input  logic                         i_Flush,
    input  logic                         i_EX_Valid,
    input  logic [NUM_SRC*REG_WIDTH-1:0] i_EX_RS,
    input  logic [REG_WIDTH-1:0]         i_EX_RdAddr,
    input  logic                         i_EX_RdWrEn,
    input  logic [AVAIL_W-1:0]           i_EX_Avail,
    output logic [NUM_SRC*SEL_W-1:0]     o_DataSel,
    output logic                         o_Stall
`ifdef FWD_STALL_STATS_EN
    ,
    output logic [31:0]                  o_StallCount
`endif
);

    typedef struct packed {
        logic                 valid;
        logic [REG_WIDTH-1:0] rd;
        logic                 wren;
        logic [AVAIL_W-1:0]   avail;
    } slot_t;

    slot_t                     r_slot [1:NUM_STAGES];
    logic [NUM_SRC-1:0]        w_hazard;
    logic [NUM_SRC*SEL_W-1:0]  w_data_sel;
    logic [AVAIL_W-1:0]        w_ex_avail;
    logic                      w_bubble;

    // An availability beyond the last slot could never be satisfied; clamp so the stall always ends.
    assign w_ex_avail = (int'(i_EX_Avail) > NUM_STAGES) ? AVAIL_W'(NUM_STAGES) : i_EX_Avail;

    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    always_comb begin
        w_hazard   = '0;
        w_data_sel = '0;
        for (int n = 0; n < NUM_SRC; n++) begin
            // Walk from the oldest slot to the youngest so the nearest match is the one left standing.
            for (int k = NUM_STAGES; k >= 1; k--) begin
                if (r_slot[k].valid && r_slot[k].wren && (r_slot[k].rd != '0) &&
                    (r_slot[k].rd == i_EX_RS[n*REG_WIDTH +: REG_WIDTH])) begin
                    if (int'(r_slot[k].avail) > k) begin
                        w_hazard[n]                  = 1'b1;
                        w_data_sel[n*SEL_W +: SEL_W] = '0;
                    end else begin
                        w_hazard[n]                  = 1'b0;
                        w_data_sel[n*SEL_W +: SEL_W] = SEL_W'(k);
                    end
                end
            end
        end
    end

    assign o_DataSel = w_data_sel;
    assign o_Stall   = i_EX_Valid & ~i_Flush & ~i_Hold & (|w_hazard);
    assign w_bubble  = o_Stall | i_Flush | ~i_EX_Valid;

    // NOTE: the slot array is reset explicitly because a reset must discard every pending write.
    // NOTE: non-blocking assignments keep the shift register ordering-independent.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            for (int k = 1; k <= NUM_STAGES; k++) begin
                r_slot[k] <= '0;
            end
        end else if (!i_Hold) begin
            for (int k = NUM_STAGES; k >= 2; k--) begin
                r_slot[k] <= r_slot[k-1];
            end
            if (w_bubble) begin
                r_slot[1] <= '0;
            end else begin
                r_slot[1] <= '{valid: 1'b1, rd: i_EX_RdAddr, wren: i_EX_RdWrEn, avail: w_ex_avail};
            end
        end
    end

`ifdef FWD_STALL_STATS_EN
    logic [31:0] r_stall_count;

    // o_Stall already excludes held cycles.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_stall_count <= '0;
        end else if (o_Stall && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign o_StallCount = r_stall_count;
`endif

endmodule

// File: tb/tb_forward_stall_unit.sv
// Bench for forward_stall_unit: a 2-src/3-stage and a 3-src/4-stage instance checked against a pending-write model.
// Directed scenarios first, then randomized traffic; honours FWD_STALL_STATS_EN for the counter port.
module tb_forward_stall_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid [2];
    logic       in_flush [2];
    logic       in_hold  [2];
    logic       in_wren  [2];
    logic [4:0] in_rd    [2];
    logic [2:0] in_avail [2];
    logic [4:0] in_rs    [2][3];

    logic [9:0]  a_rs;
    logic [1:0]  a_avail;
    logic [3:0]  a_sel;
    logic        a_stall;
    logic [14:0] b_rs;
    logic [8:0]  b_sel;
    logic        b_stall;
`ifdef FWD_STALL_STATS_EN
    logic [31:0] a_cnt;
    logic [31:0] b_cnt;
`endif

    assign a_rs    = {in_rs[0][1], in_rs[0][0]};
    assign a_avail = in_avail[0][1:0];
    assign b_rs    = {in_rs[1][2], in_rs[1][1], in_rs[1][0]};

    forward_stall_unit #(.REG_WIDTH(5), .NUM_SRC(2), .NUM_STAGES(3), .AVAIL_W(2)) dut_a (
        .i_Clock(clk), .i_Reset(rst), .i_Hold(in_hold[0]), .i_Flush(in_flush[0]),
        .i_EX_Valid(in_valid[0]), .i_EX_RS(a_rs), .i_EX_RdAddr(in_rd[0]),
        .i_EX_RdWrEn(in_wren[0]), .i_EX_Avail(a_avail), .o_DataSel(a_sel), .o_Stall(a_stall)
`ifdef FWD_STALL_STATS_EN
        , .o_StallCount(a_cnt)
`endif
    );

    forward_stall_unit #(.REG_WIDTH(5), .NUM_SRC(3), .NUM_STAGES(4), .AVAIL_W(3)) dut_b (
        .i_Clock(clk), .i_Reset(rst), .i_Hold(in_hold[1]), .i_Flush(in_flush[1]),
        .i_EX_Valid(in_valid[1]), .i_EX_RS(b_rs), .i_EX_RdAddr(in_rd[1]),
        .i_EX_RdWrEn(in_wren[1]), .i_EX_Avail(in_avail[1]), .o_DataSel(b_sel), .o_Stall(b_stall)
`ifdef FWD_STALL_STATS_EN
        , .o_StallCount(b_cnt)
`endif
    );

    // Reference model: per instance, the list of writes issued in previous cycles, indexed by age.
    typedef struct {
        bit valid;
        int rd;
        bit wren;
        int avail;
    } ent_t;

    ent_t mdl       [2][5];
    int   exp_sel   [2][3];
    bit   exp_stall [2];
    int   exp_cnt   [2];
    int   n_checks;
    int   n_errors;

    function automatic int depth_of(input int inst);
        return (inst == 0) ? 3 : 4;
    endfunction

    function automatic int nsrc_of(input int inst);
        return (inst == 0) ? 2 : 3;
    endfunction

    function automatic void mdl_clear(input int inst);
        for (int k = 0; k < 5; k++) mdl[inst][k] = '{valid: 1'b0, rd: 0, wren: 1'b0, avail: 0};
        exp_cnt[inst] = 0;
    endfunction

    // A source waits if its youngest producer has not yet aged to its availability point.
    function automatic void mdl_eval(input int inst);
        bit hz;
        bit found;
        hz = 1'b0;
        for (int n = 0; n < 3; n++) exp_sel[inst][n] = 0;
        for (int n = 0; n < nsrc_of(inst); n++) begin
            found = 1'b0;
            for (int age = 1; age <= depth_of(inst); age++) begin
                if (!found && mdl[inst][age].valid && mdl[inst][age].wren && mdl[inst][age].rd != 0 &&
                    mdl[inst][age].rd == int'(in_rs[inst][n])) begin
                    found = 1'b1;
                    if (mdl[inst][age].avail > age) hz = 1'b1;
                    else exp_sel[inst][n] = age;
                end
            end
        end
        exp_stall[inst] = in_valid[inst] && !in_flush[inst] && !in_hold[inst] && hz;
    endfunction

    function automatic void mdl_advance(input int inst);
        if (rst) begin
            mdl_clear(inst);
        end else if (!in_hold[inst]) begin
            for (int age = depth_of(inst); age >= 2; age--) mdl[inst][age] = mdl[inst][age-1];
            if (exp_stall[inst] || in_flush[inst] || !in_valid[inst]) begin
                mdl[inst][1] = '{valid: 1'b0, rd: 0, wren: 1'b0, avail: 0};
            end else begin
                assert (int'(in_avail[inst]) <= depth_of(inst)) else $error("illegal availability driven");
                mdl[inst][1] = '{valid: 1'b1, rd: int'(in_rd[inst]), wren: in_wren[inst],
                                 avail: int'(in_avail[inst])};
            end
            if (exp_stall[inst]) exp_cnt[inst]++;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic sample();
        #1;
        mdl_eval(0);
        mdl_eval(1);
        for (int n = 0; n < 2; n++) check($sformatf("a_sel[%0d]", n), 32'(a_sel[n*2 +: 2]), exp_sel[0][n]);
        check("a_stall", 32'(a_stall), 32'(exp_stall[0]));
        for (int n = 0; n < 3; n++) check($sformatf("b_sel[%0d]", n), 32'(b_sel[n*3 +: 3]), exp_sel[1][n]);
        check("b_stall", 32'(b_stall), 32'(exp_stall[1]));
`ifdef FWD_STALL_STATS_EN
        check("a_count", a_cnt, exp_cnt[0]);
        check("b_count", b_cnt, exp_cnt[1]);
`endif
    endtask

    task automatic clock_edge();
        @(posedge clk);
        mdl_advance(0);
        mdl_advance(1);
        @(negedge clk);
    endtask

    task automatic step();
        sample();
        clock_edge();
    endtask

    task automatic idle(input int inst);
        in_valid[inst] = 1'b0;
        in_flush[inst] = 1'b0;
        in_hold[inst]  = 1'b0;
        in_wren[inst]  = 1'b0;
        in_rd[inst]    = 5'd0;
        in_avail[inst] = 3'd1;
        for (int n = 0; n < 3; n++) in_rs[inst][n] = 5'd0;
    endtask

    task automatic issue(input int inst, input int rd, input bit wren, input int avail);
        in_valid[inst] = 1'b1;
        in_flush[inst] = 1'b0;
        in_hold[inst]  = 1'b0;
        in_rd[inst]    = 5'(rd);
        in_wren[inst]  = wren;
        in_avail[inst] = 3'(avail);
    endtask

    task automatic srcs(input int inst, input int r0, input int r1, input int r2);
        in_rs[inst][0] = 5'(r0);
        in_rs[inst][1] = 5'(r1);
        in_rs[inst][2] = 5'(r2);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle(0);
        idle(1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mdl_clear(0);
        mdl_clear(1);

        // Reset state
        sample();
        check("reset_a_sel", 32'(a_sel), 0);
        check("reset_b_stall", 32'(b_stall), 0);
        clock_edge();

        // Wide build: load x8 with avail 3 feeding rs3 -> two stall cycles, then slot 3
        issue(1, 8, 1'b1, 3); srcs(1, 0, 0, 0); step();
        issue(1, 9, 1'b1, 1); srcs(1, 0, 0, 8);
        sample(); check("t6_stall_c1", 32'(b_stall), 1); clock_edge();
        sample(); check("t6_stall_c2", 32'(b_stall), 1); clock_edge();
        sample(); check("t6_stall_done", 32'(b_stall), 0); check("t6_sel2", 32'(b_sel[8:6]), 3); clock_edge();
`ifdef FWD_STALL_STATS_EN
        check("t6_count", b_cnt, 2);
`endif
        idle(1);

        // ALU producer x5 forwarded from slot 1, then slot 2
        issue(0, 5, 1'b1, 1); srcs(0, 0, 0, 0); step();
        issue(0, 6, 1'b1, 1); srcs(0, 5, 0, 0);
        sample(); check("t1_sel_slot1", 32'(a_sel[1:0]), 1); check("t1_nostall", 32'(a_stall), 0); clock_edge();
        issue(0, 0, 1'b0, 1); srcs(0, 5, 0, 0);
        sample(); check("t1_sel_slot2", 32'(a_sel[1:0]), 2); clock_edge();

        // Load-use on x7: one stall cycle, then both sources from slot 2
        issue(0, 7, 1'b1, 2); srcs(0, 0, 0, 0); step();
        issue(0, 12, 1'b1, 1); srcs(0, 7, 7, 0);
        sample(); check("t2_stall", 32'(a_stall), 1); check("t2_sel_hz", 32'(a_sel), 0); clock_edge();
        sample(); check("t2_stall_done", 32'(a_stall), 0); check("t2_sel", 32'(a_sel), 4'b1010); clock_edge();

        // Nearest producer wins; x0 is never forwarded
        issue(0, 3, 1'b1, 1); srcs(0, 0, 0, 0); step();
        issue(0, 3, 1'b1, 1); step();
        issue(0, 0, 1'b1, 1); srcs(0, 3, 0, 0);
        sample(); check("t3_nearest", 32'(a_sel[1:0]), 1); clock_edge();
        issue(0, 13, 1'b0, 1); srcs(0, 0, 3, 0);
        sample(); check("t3_x0", 32'(a_sel[1:0]), 0); check("t3_older", 32'(a_sel[3:2]), 2); clock_edge();

        // Hold in the middle of a load-use stall freezes the slots
        issue(0, 9, 1'b1, 2); srcs(0, 0, 0, 0); step();
        issue(0, 14, 1'b1, 1); srcs(0, 9, 0, 0);
        in_hold[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample(); check("t4_hold_nostall", 32'(a_stall), 0); clock_edge();
        end
        in_hold[0] = 1'b0;
        sample(); check("t4_stall_after_hold", 32'(a_stall), 1); clock_edge();
        sample(); check("t4_sel_after", 32'(a_sel[1:0]), 2); clock_edge();

        // Flush with a hazard: no stall, bubble into slot 1
        issue(0, 10, 1'b1, 2); srcs(0, 0, 0, 0); step();
        issue(0, 11, 1'b1, 1); srcs(0, 10, 0, 0); in_flush[0] = 1'b1;
        sample(); check("t4_flush_nostall", 32'(a_stall), 0); clock_edge();
        issue(0, 15, 1'b1, 1); srcs(0, 11, 10, 0);
        sample(); check("t4_bubble", 32'(a_sel[1:0]), 0); check("t4_load_slot2", 32'(a_sel[3:2]), 2); clock_edge();

        // Reset with every slot occupied
        for (int i = 0; i < 3; i++) begin
            issue(0, 1 + i, 1'b1, 1); srcs(0, 0, 0, 0); step();
        end
        rst = 1'b1;
        issue(0, 16, 1'b1, 1); srcs(0, 1, 2, 0);
        step();
        rst = 1'b0;
        sample();
        check("t5_sel", 32'(a_sel), 0);
        check("t5_stall", 32'(a_stall), 0);
`ifdef FWD_STALL_STATS_EN
        check("t5_count_a", a_cnt, 0);
        check("t5_count_b", b_cnt, 0);
`endif
        clock_edge();

        // Randomized traffic on both instances
        for (int i = 0; i < 800; i++) begin
            for (int inst = 0; inst < 2; inst++) begin
                in_valid[inst] = ($urandom_range(0, 4) != 0);
                in_flush[inst] = ($urandom_range(0, 9) == 0);
                in_hold[inst]  = ($urandom_range(0, 9) == 0);
                in_wren[inst]  = ($urandom_range(0, 3) != 0);
                in_rd[inst]    = 5'($urandom_range(0, 7));
                in_avail[inst] = 3'($urandom_range(0, depth_of(inst)));
                for (int n = 0; n < 3; n++) in_rs[inst][n] = 5'($urandom_range(0, 7));
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        idle(0);
        idle(1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
